alu16: RTL and testbench
========================

# alu16

16-bit two's-complement arithmetic/logic unit with a registered result, high word and status flags. Each clock it executes the 4-bit opcode `ins` on operands `A` and `B`. It sits in the datapath execute stage, with `hi` carrying the multiply upper word, divide remainder or shift spill. Module name: `alu16`.

## Interface
- No parameters; width fixed at 16.
- `clk`   input   1    rising-edge clock (one clock domain)
- `rst`   input   1    asynchronous, active-high reset
- `A`     input   16   operand A, two's complement
- `B`     input   16   operand B, two's complement; `B[3:0]` is the shift amount
- `ins`   input   4    opcode
- `out`   output  16   signed result, registered
- `flags` output  3    registered flags: [2] overflow, [1] negative, [0] zero
- `hi`    output  16   signed auxiliary word, registered

## Operation
- 0 NOP: out=0, hi=0.
- 1 ADD: out=A+B, hi=0. Overflow on signed overflow.
- 2 SUB: out=A−B, hi=0. Overflow on signed overflow.
- 3 MUL: signed 32-bit product, with {hi,out} = A×B. Overflow when the product does not fit in 16 signed bits.
- 4 DIV: out=quotient, truncated toward zero. hi=remainder, taking the sign of A.
  - B=0: out=0, hi=A, overflow=1.
  - A=−32768 and B=−1: out=−32768, hi=0, overflow=1.
- 5 AND, 6 OR, 7 XOR: bitwise on out, hi=0.
- 8 SHL: out=A<<B[3:0]. hi = upper 16 bits of ({16'b0,A}<<B[3:0]).
- 9 SAR: out=A>>>B[3:0], hi=0.
- 10–15 reserved: behave as NOP.
- Overflow is 0 for every opcode except 1–4.
- Negative = out[15]. Zero = (out==0). Both are computed from out only, for every opcode.

## Timing
- Combinational compute feeds one register stage, giving one-cycle latency.
  - `A`, `B` and `ins` are sampled at a `clk` rising edge.
  - `out`, `flags` and `hi` update at that edge.
- A new operation may issue every cycle. There is no handshake and no stall.
- Divide completes in the same single cycle.
- `rst` asserted: `out`, `hi` and `flags` go to 0 immediately, independent of `clk`. They hold 0 while `rst` is high.
- Reset wins over a simultaneous clock edge.
- The first edge after `rst` deasserts loads a normal result.
- Reset mid-stream discards the in-flight result; nothing is replayed.

## Configuration
- `ALU_DIV_EN` defined: opcode 4 is implemented as specified above.
- `ALU_DIV_EN` undefined:
  - The divider is not compiled.
  - Opcode 4 produces out=0, hi=0, flags=3'b101 (overflow plus zero). This marks it unsupported.
- All other opcodes are unaffected either way.

## Structure
- Shared package `alu16_pkg` holds:
  - the opcode constants (OP_NOP … OP_SAR)
  - the flag bit index constants (FLAG_V=2, FLAG_N=1, FLAG_Z=0)
  - the width constant (16)
- One sub-module, `alu16_div`:
  - combinational signed restoring divider producing quotient, remainder and div-by-zero/overflow indication
  - instantiated only under `ALU_DIV_EN`
- Top level contains the opcode decode mux, flag logic and output registers.

## Test plan
- Reset: assert `rst` mid-operation → out=0, hi=0, flags=000 with no clock edge. Release, then A=3, B=511, ins=1 → next edge: out=514, flags=000.
- A=3, B=511, one opcode per cycle, results one edge later:
  - SUB → out=−508, flags=010
  - MUL → out=1533, hi=0
  - DIV → out=0, hi=3, flags=001
  - AND → 3
  - OR → 511
  - XOR → 508
  - SHL → out=−32768, hi=1, flags=010
  - SAR → out=0, flags=001
- Overflow:
  - ADD 32767+1 → out=−32768, flags=110
  - MUL 300×300 → hi=1, out=24464, flags=100
- Divide corners:
  - −7/2 → out=−3, hi=−1
  - 5/0 → out=0, hi=5, flags=101
  - −32768/−1 → out=−32768, flags=110
- Reserved opcode 12 with A=B=1 → out=0, hi=0, flags=001.
- Build without `ALU_DIV_EN`: DIV 10/3 → out=0, hi=0, flags=101. ADD is still correct.

Source files
------------

// File: rtl/alu16_pkg.sv
// alu16 shared constants: opcodes, flag bit positions, datapath width.
// Divide support is selected by the ALU_DIV_EN macro.
package alu16_pkg;

   localparam int W = 16;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SAR = 4'd9;

   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu16_div.sv
// alu16_div: single-cycle signed restoring divider (truncating quotient).
// Only instantiated when ALU_DIV_EN is defined.
module alu16_div
   import alu16_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] quo,
   output logic [W-1:0] rem,
   output logic         dz,
   output logic         ovf
);

   logic [W-1:0] ua;
   logic [W-1:0] ub;
   logic [W-1:0] uq;
   logic [W:0]   r;

   // Divide magnitudes bit-serially, then restore signs; /0 passes A through.
   always_comb begin
      ua  = a[W-1] ? (~a + 1'b1) : a;
      ub  = b[W-1] ? (~b + 1'b1) : b;
      uq  = '0;
      r   = '0;
      for (int i = W - 1; i >= 0; i--) begin
         r = {r[W-1:0], ua[i]};
         if (r >= {1'b0, ub}) begin
            r     = r - {1'b0, ub};
            uq[i] = 1'b1;
         end
      end
      dz  = (b == '0);
      ovf = (a == 16'h8000) && (b == 16'hFFFF);
      quo = (a[W-1] ^ b[W-1]) ? (~uq + 1'b1) : uq;
      rem = a[W-1] ? (~r[W-1:0] + 1'b1) : r[W-1:0];
      if (dz) begin
         quo = '0;
         rem = a;
      end
   end

endmodule

// File: rtl/alu16.sv
// alu16: 16-bit ALU, one-cycle registered result, high word and flags.
// Define ALU_DIV_EN to build the divider; otherwise DIV reports unsupported.
module alu16
   import alu16_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [3:0]   ins,
   output logic [W-1:0] out,
   output logic [2:0]   flags,
   output logic [W-1:0] hi
);

   logic [W-1:0]   add_r;
   logic [W-1:0]   sub_r;
   logic [2*W-1:0] ea;
   logic [2*W-1:0] eb;
   logic [2*W-1:0] mul_r;
   logic [2*W-1:0] shl_r;
   logic [W-1:0]   sar_r;
   logic [W-1:0]   res;
   logic [W-1:0]   res_hi;
   logic           v;
   logic [2:0]     fl;

   assign add_r = A + B;
   assign sub_r = A - B;
   assign ea    = {{W{A[W-1]}}, A};
   assign eb    = {{W{B[W-1]}}, B};
   assign mul_r = ea * eb;
   assign shl_r = {{W{1'b0}}, A} << B[3:0];
   assign sar_r = $signed(A) >>> B[3:0];

`ifdef ALU_DIV_EN
   logic [W-1:0] d_quo;
   logic [W-1:0] d_rem;
   logic         d_dz;
   logic         d_ovf;

   alu16_div u_div (
      .a   (A),
      .b   (B),
      .quo (d_quo),
      .rem (d_rem),
      .dz  (d_dz),
      .ovf (d_ovf)
   );
`endif

   // Opcode decode: select result, high word and overflow.
   always_comb begin
      res    = '0;
      res_hi = '0;
      v      = 1'b0;
      case (ins)
         OP_ADD: begin
            res = add_r;
            v   = (A[W-1] == B[W-1]) && (add_r[W-1] != A[W-1]);
         end
         OP_SUB: begin
            res = sub_r;
            v   = (A[W-1] != B[W-1]) && (sub_r[W-1] != A[W-1]);
         end
         OP_MUL: begin
            res    = mul_r[W-1:0];
            res_hi = mul_r[2*W-1:W];
            v      = (mul_r[2*W-1:W-1] != '0) && (mul_r[2*W-1:W-1] != '1);
         end
         OP_DIV: begin
`ifdef ALU_DIV_EN
            res    = d_quo;
            res_hi = d_rem;
            v      = d_dz | d_ovf;
`else
            v      = 1'b1;
`endif
         end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_XOR: res = A ^ B;
         OP_SHL: begin
            res    = shl_r[W-1:0];
            res_hi = shl_r[2*W-1:W];
         end
         OP_SAR: res = sar_r;
         default: begin
            res    = '0;
            res_hi = '0;
            v      = 1'b0;
         end
      endcase
   end

   // Negative and zero always follow the selected result.
   always_comb begin
      fl         = '0;
      fl[FLAG_V] = v;
      fl[FLAG_N] = res[W-1];
      fl[FLAG_Z] = (res == '0);
   end

   // Output register; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out   <= '0;
         hi    <= '0;
         flags <= '0;
      end else begin
         out   <= res;
         hi    <= res_hi;
         flags <= fl;
      end
   end

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed vectors with hand-computed results for alu16.
// Divide expectations follow whether ALU_DIV_EN is defined.
module tb_alu16;

   logic        clk;
   logic        rst;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  ins;
   logic [15:0] out;
   logic [2:0]  flags;
   logic [15:0] hi;

   int checks   = 0;
   int failures = 0;

   alu16 dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .ins   (ins),
      .out   (out),
      .flags (flags),
      .hi    (hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic all3(input string tag, input logic [15:0] eo,
                       input logic [15:0] eh, input logic [2:0] ef);
      chk({tag, ".out"}, out, eo);
      chk({tag, ".hi"}, hi, eh);
      chk({tag, ".flags"}, {13'd0, flags}, {13'd0, ef});
   endtask

   task automatic run(input string tag, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eo, input logic [15:0] eh,
                      input logic [2:0] ef);
      @(negedge clk);
      A   = a;
      B   = b;
      ins = op;
      @(posedge clk);
      #1;
      all3(tag, eo, eh, ef);
   endtask

   initial begin
      rst = 1'b1;
      A   = 16'd3;
      B   = 16'd511;
      ins = 4'd1;
      #2;
      all3("reset_init", 16'd0, 16'd0, 3'b000);
      @(posedge clk);
      #1;
      all3("reset_hold", 16'd0, 16'd0, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      run("mul_pre", 4'd3, 16'd300, 16'd300, 16'd24464, 16'd1, 3'b100);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      all3("reset_async", 16'd0, 16'd0, 3'b000);
      @(posedge clk);
      #1;
      all3("reset_edge", 16'd0, 16'd0, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      run("add", 4'd1, 16'd3, 16'd511, 16'd514, 16'd0, 3'b000);
      run("sub", 4'd2, 16'd3, 16'd511, 16'(-508), 16'd0, 3'b010);
      run("mul", 4'd3, 16'd3, 16'd511, 16'd1533, 16'd0, 3'b000);
`ifdef ALU_DIV_EN
      run("div", 4'd4, 16'd3, 16'd511, 16'd0, 16'd3, 3'b001);
`else
      run("div", 4'd4, 16'd3, 16'd511, 16'd0, 16'd0, 3'b101);
`endif
      run("and", 4'd5, 16'd3, 16'd511, 16'd3, 16'd0, 3'b000);
      run("or", 4'd6, 16'd3, 16'd511, 16'd511, 16'd0, 3'b000);
      run("xor", 4'd7, 16'd3, 16'd511, 16'd508, 16'd0, 3'b000);
      run("shl", 4'd8, 16'd3, 16'd511, 16'h8000, 16'd1, 3'b010);
      run("sar", 4'd9, 16'd3, 16'd511, 16'd0, 16'd0, 3'b001);
      run("sar_neg", 4'd9, 16'h8000, 16'd4, 16'hF800, 16'd0, 3'b010);
      run("shl_0", 4'd8, 16'h1234, 16'd0, 16'h1234, 16'd0, 3'b000);

      run("add_ovf", 4'd1, 16'd32767, 16'd1, 16'h8000, 16'd0, 3'b110);
      run("sub_ovf", 4'd2, 16'h8000, 16'd1, 16'h7FFF, 16'd0, 3'b100);
      run("mul_ovf", 4'd3, 16'd300, 16'd300, 16'd24464, 16'd1, 3'b100);
      run("mul_neg", 4'd3, 16'(-3), 16'd5, 16'(-15), 16'hFFFF, 3'b010);

`ifdef ALU_DIV_EN
      run("div_neg", 4'd4, 16'(-7), 16'd2, 16'(-3), 16'hFFFF, 3'b010);
      run("div_z", 4'd4, 16'd5, 16'd0, 16'd0, 16'd5, 3'b101);
      run("div_min", 4'd4, 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 3'b110);
      run("div_10_3", 4'd4, 16'd10, 16'd3, 16'd3, 16'd1, 3'b000);
`else
      run("div_neg", 4'd4, 16'(-7), 16'd2, 16'd0, 16'd0, 3'b101);
      run("div_z", 4'd4, 16'd5, 16'd0, 16'd0, 16'd0, 3'b101);
      run("div_min", 4'd4, 16'h8000, 16'hFFFF, 16'd0, 16'd0, 3'b101);
      run("div_10_3", 4'd4, 16'd10, 16'd3, 16'd0, 16'd0, 3'b101);
`endif

      run("rsvd12", 4'd12, 16'd1, 16'd1, 16'd0, 16'd0, 3'b001);
      run("rsvd15", 4'd15, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 3'b001);
      run("nop", 4'd0, 16'd7, 16'd9, 16'd0, 16'd0, 3'b001);
      run("add_mix", 4'd1, 16'd100, 16'(-30), 16'd70, 16'd0, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
